bnn_conv_stream: RTL and testbench
==================================

BNN_CONV_STREAM -- requirements
Module: bnn_conv_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, meaning input image height in pixels.
REQ-003 SHALL have parameter K, default 5, meaning square kernel size (stride 1, no padding).
REQ-004 SHALL have parameter C_IN, default 1, meaning binary input channels per pixel.
REQ-005 SHALL have parameter N_OUT, default 18, meaning output channels.
REQ-006 SHALL have parameter bW, default 8, meaning threshold width; bW >= PW = clog2(K*K*C_IN+1); violation is an elaboration error.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-008 SHALL have clr, input, 1 bit: synchronous soft clear.
REQ-009 SHALL have in_data, input, C_IN bits: one pixel, raster order.
REQ-010 SHALL have in_valid, input, 1 bit, and in_ready, output, 1 bit: pixel handshake.
REQ-011 SHALL have kernels, input, N_OUT*K*K*C_IN bits: weights, static during a frame.
REQ-012 SHALL have kernel_offset, input, N_OUT*bW bits: per-channel unsigned thresholds.
REQ-013 SHALL have thr_inv, input, N_OUT bits: per-channel output inversion.
REQ-014 SHALL have out_data, output, N_OUT bits: one binary output pixel, all channels.
REQ-015 SHALL have out_valid, output, 1 bit, and out_ready, input, 1 bit: output handshake.
REQ-016 SHALL have out_last, output, 1 bit: marks the final output pixel of a frame.

Function
REQ-017 SHALL accept a pixel only when in_valid && in_ready are both high; in_ready = !out_valid || out_ready.
REQ-018 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advancing per accepted pixel; col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both wrap to 0 for the next frame.
REQ-019 SHALL hold the last K-1 rows in a line buffer plus a KxK window of C_IN-bit pixels.
REQ-020 SHALL, on acceptance of a pixel with row >= K-1 and col >= K-1, produce one output pixel; this gives (IMG_H-K+1)*(IMG_W-K+1) outputs per frame (576 at defaults).
REQ-021 SHALL, per channel n, set popcount P = number of equal bits (XNOR) between the window and kernels[n*K*K*C_IN + (r*K+c)*C_IN + ch]; r=0 is the oldest row, c=0 the leftmost column.
REQ-022 SHALL set out_data[n] = (P >= kernel_offset[n]) XOR thr_inv[n], with P zero-extended to bW bits and an unsigned compare.
REQ-023 SHALL register the result: out_valid rises the cycle after the completing pixel is accepted (latency 1); out_data and out_last hold stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid after an out_ready handshake unless a new result loads in the same cycle; simultaneous output drain and input accept SHALL be lossless.
REQ-025 SHALL assert out_last with the output for row IMG_H-1, col IMG_W-1.
REQ-026 SHALL, on clr, zero row/col, clear out_valid and out_last, discard window contents, and ignore any pixel presented that cycle.
REQ-027 SHALL be unaffected by in_data while in_valid is low; kernel or threshold changes mid-frame are undefined.

Reset
REQ-028 SHALL, while rst_n is low, force row=0, col=0, out_valid=0, out_last=0, out_data=0; in_ready SHALL be 1 after reset.
REQ-029 SHALL, on reset asserted mid-frame, discard the partial frame; the first pixel after release is pixel (0,0).

Verification
REQ-030 All-ones image, all-ones kernels, all offsets 25, thr_inv=0 -> 576 outputs, each 18'h3FFFF; first output after the 117th accepted pixel; out_last only on the 576th.
REQ-031 All-zero image, all-ones kernels: offsets 1 -> all outputs 0; offsets 0 -> all outputs 18'h3FFFF.
REQ-032 Repeat REQ-030 with thr_inv=18'h00001 -> every output is 18'h3FFFE.
REQ-033 out_ready low for 10 cycles at the first output -> in_ready low, out_data stable, no pixel lost; 576 outputs total.
REQ-034 rst_n pulsed after 300 pixels, then a full frame -> exactly 576 outputs; clr at pixel 300 gives the same result.
REQ-035 Random image/kernels/offsets, random valid/ready gaps, C_IN=2, K=3 -> every output matches the golden model bit-exactly.

Source files
------------

// File: rtl/bnn_conv_stream.sv
// Streaming binary conv: line buffer + KxK window, XNOR-popcount vs per-channel threshold, stride 1.
// One registered output per completing pixel (latency 1); in_ready drops only while an output is held.
module bnn_conv_stream #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 5,
   parameter int C_IN  = 1,
   parameter int N_OUT = 18,
   parameter int bW    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic [C_IN-1:0]             in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_OUT*K*K*C_IN-1:0]   kernels,
   input  logic [N_OUT*bW-1:0]         kernel_offset,
   input  logic [N_OUT-1:0]            thr_inv,
   output logic [N_OUT-1:0]            out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last
);
   localparam int KK = K * K * C_IN;
   localparam int PW = $clog2(KK + 1);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   generate
      if (bW < PW) begin : g_bw_too_small
         $error("bnn_conv_stream: bW must be >= clog2(K*K*C_IN+1)");
      end
      if (K < 2) begin : g_k_too_small
         $error("bnn_conv_stream: K must be >= 2");
      end
   endgenerate

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [KK-1:0]     win_q, win_d, win_nxt;
   logic [N_OUT-1:0]  out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [C_IN-1:0]   lb_q [K-1][IMG_W];
   logic [C_IN-1:0]   lb_d [K-1][IMG_W];
   logic [C_IN-1:0]   col_vec [K];
   logic [N_OUT-1:0]  res;
   logic [PW-1:0]     pop;
   logic              accept, fire, at_last_col, at_last_row;

   assign in_ready    = !out_valid_q || out_ready;
   assign accept      = in_valid && in_ready && !clr;
   assign at_last_col = (col_q == CW'(IMG_W - 1));
   assign at_last_row = (row_q == RW'(IMG_H - 1));
   assign fire        = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (accept) begin
         if (at_last_col) begin
            col_d = '0;
            row_d = at_last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Column entering the window: K-1 buffered rows (oldest first) plus the live pixel.
   always_comb begin
      col_vec = '{default: '0};
      for (int r = 0; r < K - 1; r++) begin
         col_vec[r] = lb_q[r][col_q];
      end
      col_vec[K-1] = in_data;
   end

   always_comb begin
      lb_d = lb_q;
      if (accept) begin
         for (int r = 0; r < K - 1; r++) begin
            lb_d[r][col_q] = col_vec[r+1];
         end
      end
   end

   always_comb begin
      win_nxt = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            win_nxt[(r*K+c)*C_IN +: C_IN] = win_q[(r*K+c+1)*C_IN +: C_IN];
         end
         win_nxt[(r*K+K-1)*C_IN +: C_IN] = col_vec[r];
      end
      win_d = win_q;
      if (clr) begin
         win_d = '0;
      end else if (accept) begin
         win_d = win_nxt;
      end
   end

   // Threshold is evaluated on the window as it will look after this pixel shifts in.
   always_comb begin
      res = '0;
      pop = '0;
      for (int n = 0; n < N_OUT; n++) begin
         pop = '0;
         for (int i = 0; i < KK; i++) begin
            if (win_nxt[i] == kernels[n*KK+i]) begin
               pop = pop + PW'(1);
            end
         end
         res[n] = (bW'(pop) >= kernel_offset[n*bW +: bW]) ^ thr_inv[n];
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      if (clr) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else if (fire) begin
         out_valid_d = 1'b1;
         out_data_d  = res;
         out_last_d  = at_last_row && at_last_col;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Line buffer rows are always rewritten before they reach the window, so no reset is needed.
   always_ff @(posedge clk) begin
      lb_q <= lb_d;
   end

endmodule

// File: tb/tb_bnn_conv_stream.sv
// Directed frames on a default-size instance plus a randomized small instance against a golden model.
module tb_bnn_conv_stream;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out", name);
   endtask

   // ---------------- instance A: default parameters ----------------
   logic         a_clr = 1'b0;
   logic [0:0]   a_in_data = '0;
   logic         a_in_valid = 1'b0;
   logic         a_in_ready;
   logic [449:0] a_kernels = '0;
   logic [143:0] a_off = '0;
   logic [17:0]  a_inv = '0;
   logic [17:0]  a_out_data;
   logic         a_out_valid;
   logic         a_out_ready = 1'b1;
   logic         a_out_last;

   bnn_conv_stream #(.IMG_W(28), .IMG_H(28), .K(5), .C_IN(1), .N_OUT(18), .bW(8)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(a_clr),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .kernels(a_kernels), .kernel_offset(a_off), .thr_inv(a_inv),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_last(a_out_last)
   );

   // ---------------- instance B: K=3, C_IN=2, small image ----------------
   localparam int BWD = 7, BH = 6, BK = 3, BC = 2, BN = 4, BB = 5, BKK = BK*BK*BC;
   logic              b_clr = 1'b0;
   logic [BC-1:0]     b_in_data = '0;
   logic              b_in_valid = 1'b0;
   logic              b_in_ready;
   logic [BN*BKK-1:0] b_kernels = '0;
   logic [BN*BB-1:0]  b_off = '0;
   logic [BN-1:0]     b_inv = '0;
   logic [BN-1:0]     b_out_data;
   logic              b_out_valid;
   logic              b_out_ready = 1'b1;
   logic              b_out_last;
   logic              b_rand_rdy = 1'b0;

   bnn_conv_stream #(.IMG_W(BWD), .IMG_H(BH), .K(BK), .C_IN(BC), .N_OUT(BN), .bW(BB)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(b_clr),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .kernels(b_kernels), .kernel_offset(b_off), .thr_inv(b_inv),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_last(b_out_last)
   );

   typedef struct {
      logic        img;
      logic        kern;
      logic [7:0]  off_e;
      logic [7:0]  off_o;
      logic [17:0] inv;
      logic [17:0] exp;
   } vec_t;

   // ---------------- monitors (sample on negedge) ----------------
   logic [17:0] a_exp = '0;
   int a_out_cnt = 0, a_last_cnt = 0, a_last_at = 0, a_first_acc = -1, a_acc_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (a_out_valid && a_out_ready) begin
            if (a_out_cnt == 0) a_first_acc = a_acc_cnt;
            a_out_cnt++;
            check("a_data", a_out_data, a_exp);
            if (a_out_last) begin
               a_last_cnt++;
               a_last_at = a_out_cnt;
            end
         end
         if (a_in_valid && a_in_ready && !a_clr) a_acc_cnt++;
      end
   end

   logic [BN:0] b_q[$];
   int b_out_cnt = 0;

   always @(negedge clk) begin
      logic [BN:0] e;
      if (rst_n && b_out_valid && b_out_ready) begin
         if (b_q.size() == 0) begin
            timeout_fail("b_unexpected_output");
         end else begin
            e = b_q.pop_front();
            check("b_data", b_out_data, e[BN-1:0]);
            check("b_last", b_out_last, e[BN]);
            b_out_cnt++;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (b_rand_rdy) b_out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- tasks ----------------
   task automatic a_cfg(input vec_t v);
      a_kernels = {450{v.kern}};
      for (int n = 0; n < 18; n++) a_off[n*8 +: 8] = (n % 2 == 0) ? v.off_e : v.off_o;
      a_inv = v.inv;
      a_exp = v.exp;
   endtask

   task automatic a_start();
      a_out_cnt = 0; a_last_cnt = 0; a_last_at = 0; a_first_acc = -1; a_acc_cnt = 0;
   endtask

   task automatic a_push(input int n, input logic v);
      for (int i = 0; i < n; i++) begin
         int  g;
         logic acc;
         g = 0;
         acc = 1'b0;
         a_in_valid = 1'b1;
         a_in_data  = v;
         while (!acc) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
            g++;
            if (!acc && g > 2000) begin
               timeout_fail("a_push");
               a_in_valid = 1'b0;
               return;
            end
         end
      end
      a_in_valid = 1'b0;
   endtask

   task automatic a_frame_checks(input string tag);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_count"}, a_out_cnt, 576);
      check({tag, "_last_cnt"}, a_last_cnt, 1);
      check({tag, "_last_at"}, a_last_at, 576);
      check({tag, "_first_acc"}, a_first_acc, 117);
   endtask

   logic [BC-1:0] b_img [BH][BWD];

   task automatic b_model();
      for (int r = BK - 1; r < BH; r++) begin
         for (int c = BK - 1; c < BWD; c++) begin
            logic [BN:0] e;
            e = '0;
            for (int n = 0; n < BN; n++) begin
               int p;
               p = 0;
               for (int kr = 0; kr < BK; kr++)
                  for (int kc = 0; kc < BK; kc++)
                     for (int ch = 0; ch < BC; ch++)
                        if (b_kernels[n*BKK + (kr*BK+kc)*BC + ch] == b_img[r-BK+1+kr][c-BK+1+kc][ch]) p++;
               e[n] = (p >= int'(b_off[n*BB +: BB])) ^ b_inv[n];
            end
            e[BN] = (r == BH - 1) && (c == BWD - 1);
            b_q.push_back(e);
         end
      end
   endtask

   task automatic b_push_frame();
      for (int r = 0; r < BH; r++) begin
         for (int c = 0; c < BWD; c++) begin
            int  g;
            logic acc;
            repeat ($urandom_range(0, 2)) begin
               b_in_valid = 1'b0;
               b_in_data  = 2'($urandom);
               @(posedge clk);
               #1;
            end
            g = 0;
            acc = 1'b0;
            b_in_valid = 1'b1;
            b_in_data  = b_img[r][c];
            while (!acc) begin
               @(negedge clk);
               acc = b_in_ready;
               @(posedge clk);
               #1;
               g++;
               if (!acc && g > 2000) begin
                  timeout_fail("b_push");
                  b_in_valid = 1'b0;
                  return;
               end
            end
         end
      end
      b_in_valid = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   vec_t vt [8];

   initial begin
      logic [17:0] held;
      int g;

      vt[0] = '{1'b1, 1'b1, 8'd25, 8'd25,  18'h00000, 18'h3FFFF};
      vt[1] = '{1'b0, 1'b1, 8'd1,  8'd1,   18'h00000, 18'h00000};
      vt[2] = '{1'b0, 1'b1, 8'd0,  8'd0,   18'h00000, 18'h3FFFF};
      vt[3] = '{1'b1, 1'b1, 8'd25, 8'd25,  18'h00001, 18'h3FFFE};
      vt[4] = '{1'b1, 1'b1, 8'd25, 8'd26,  18'h00000, 18'h15555};
      vt[5] = '{1'b0, 1'b0, 8'd25, 8'd25,  18'h00000, 18'h3FFFF};
      vt[6] = '{1'b1, 1'b0, 8'd0,  8'd1,   18'h00000, 18'h15555};
      vt[7] = '{1'b1, 1'b1, 8'd24, 8'd255, 18'h3FFFF, 18'h2AAAA};

      a_cfg(vt[0]);
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_out_valid", a_out_valid, 0);
      check("rst_a_out_last", a_out_last, 0);
      check("rst_a_out_data", a_out_data, 0);
      check("rst_b_out_valid", b_out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_a_in_ready", a_in_ready, 1);
      check("rst_b_in_ready", b_in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         a_cfg(vt[i]);
         a_start();
         a_push(784, vt[i].img);
         a_frame_checks($sformatf("vec%0d", i));
      end

      // Output stalled for 10 cycles at the first result.
      a_cfg(vt[0]);
      a_start();
      a_out_ready = 1'b0;
      fork
         a_push(784, 1'b1);
         begin
            g = 0;
            while (!a_out_valid && g < 2000) begin
               @(negedge clk);
               g++;
            end
            check("stall_seen", a_out_valid, 1);
            held = a_out_data;
            repeat (10) begin
               @(negedge clk);
               check("stall_in_ready", a_in_ready, 0);
               check("stall_out_valid", a_out_valid, 1);
               check("stall_out_data", a_out_data, held);
            end
            @(posedge clk);
            #1;
            a_out_ready = 1'b1;
         end
      join
      a_frame_checks("stall");

      // Reset in the middle of a frame.
      a_start();
      a_push(300, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_out_valid", a_out_valid, 0);
      check("midrst_out_data", a_out_data, 0);
      check("midrst_out_last", a_out_last, 0);
      check("midrst_in_ready", a_in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      a_start();
      a_push(784, 1'b1);
      a_frame_checks("midrst");

      // Soft clear in the middle of a frame, with a pixel presented alongside it.
      a_start();
      a_push(300, 1'b1);
      a_clr = 1'b1;
      a_in_valid = 1'b1;
      a_in_data = 1'b0;
      @(posedge clk);
      #1;
      a_clr = 1'b0;
      a_in_valid = 1'b0;
      check("clr_out_valid", a_out_valid, 0);
      check("clr_out_last", a_out_last, 0);
      a_start();
      a_push(784, 1'b1);
      a_frame_checks("clr");

      // Randomized frames with gaps on both sides.
      b_rand_rdy = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int r = 0; r < BH; r++)
            for (int c = 0; c < BWD; c++) b_img[r][c] = 2'($urandom);
         for (int i = 0; i < BN*BKK; i++) b_kernels[i] = 1'($urandom);
         for (int n = 0; n < BN; n++) b_off[n*BB +: BB] = BB'($urandom_range(0, 19));
         b_inv = 4'($urandom);
         b_model();
         b_push_frame();
      end
      b_rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      b_out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("b_remaining", b_q.size(), 0);
      check("b_out_count", b_out_cnt, 3 * (BH - BK + 1) * (BWD - BK + 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
